// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Owns the tag/valid store and sequences the data array and memory handshakes.
module cache_controller #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned CACHE_DEPTH = 8,
    localparam int unsigned INDEX_W    = $clog2(CACHE_DEPTH),
    localparam int unsigned TAG_W      = ADDR_WIDTH - INDEX_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ready,
    output logic                  cpu_busy,
    output logic                  hit,
    output logic                  miss,
    output logic                  mem_rd_req,
    output logic                  mem_wr_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  cache_wr_en,
    output logic                  cache_rd_en,
    output logic [INDEX_W-1:0]    cache_index,
    output logic [DATA_WIDTH-1:0] cache_data_in,
    input  logic [DATA_WIDTH-1:0] cache_data_out
);

    typedef enum logic [1:0] {IDLE, COMPARE, FETCH, WRITE} state_t;

    state_t                  state;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [CACHE_DEPTH-1:0]  valid;
    logic [TAG_W-1:0]        tag_store [CACHE_DEPTH];

    logic [INDEX_W-1:0]      idx;
    logic [TAG_W-1:0]        tag;
    logic                    match;

    assign idx   = addr_q[INDEX_W-1:0];
    assign tag   = addr_q[ADDR_WIDTH-1:INDEX_W];
    assign match = valid[idx] && (tag_store[idx] == tag);

    // Array-facing strobes are decoded from state so they align with the cycle
    // in which the data array must act (falling-edge write, combinational read).
    always_comb begin
        hit           = 1'b0;
        miss          = 1'b0;
        cache_rd_en   = 1'b0;
        cache_wr_en   = 1'b0;
        cache_data_in = '0;
        case (state)
            COMPARE: begin
                hit           = match;
                miss          = !match;
                cache_rd_en   = match && !we_q;
                cache_wr_en   = match && we_q;
                cache_data_in = wdata_q;
            end
            FETCH: begin
                cache_wr_en   = mem_ack;
                cache_data_in = mem_rdata;
            end
            default: ;
        endcase
    end

    assign mem_rd_req  = (state == FETCH);
    assign mem_wr_req  = (state == WRITE);
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign cache_index = idx;
    assign cpu_busy    = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            valid     <= '0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            for (int unsigned i = 0; i < CACHE_DEPTH; i++) begin
                tag_store[i] <= '0;
            end
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        we_q    <= cpu_we;
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                        state   <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (we_q) begin
                        state <= WRITE;
                    end else if (match) begin
                        cpu_rdata <= cache_data_out;
                        cpu_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        tag_store[idx] <= tag;
                        valid[idx]     <= 1'b1;
                        cpu_rdata      <= mem_rdata;
                        cpu_ready      <= 1'b1;
                        state          <= IDLE;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        cpu_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
